// File: rtl/mont_pkg.sv
// Shared constants and types for the Montgomery-domain encoder (default modulus 3329, radix 2^12).
package mont_pkg;

  localparam int N       = 3329;
  localparam int R       = 12;
  localparam int N_PRIME = 3327;          // -N^-1 mod 2^R, used by the matching reducer
  localparam int DATA_W  = 12;
  localparam int CNT_W   = $clog2(R);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/mod_double.sv
// Combinational modular doubling: y = 2x mod N, valid for any x < N.
module mod_double #(
  parameter int N = mont_pkg::N
) (
  input  logic [mont_pkg::DATA_W-1:0] x,
  output logic [mont_pkg::DATA_W-1:0] y
);

  localparam int W  = mont_pkg::DATA_W;
  localparam int W1 = W + 1;
  localparam logic [W:0] N_EXT = W1'(N);

  logic [W:0]   w_twice;
  logic [W-1:0] w_diff;

  assign w_twice = {x, 1'b0};
  // Low bits of the subtraction are exact whenever t >= N, so the borrow bit is never needed.
  assign w_diff  = w_twice[W-1:0] - N_EXT[W-1:0];
  assign y       = (w_twice >= N_EXT) ? w_diff : w_twice[W-1:0];

endmodule

// File: rtl/montgomery_encode.sv
// Serial conversion a -> a*2^R mod N by R modular doublings, one per clock.
// Optional input range check (adds port err) enabled by defining MONT_ENC_RANGE_CHK_EN.
module montgomery_encode #(
  parameter int N = mont_pkg::N,
  parameter int R = mont_pkg::R
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] a,
  output logic [11:0] y,
  output logic        valid,
  output logic        busy
`ifdef MONT_ENC_RANGE_CHK_EN
  ,
  output logic        err
`endif
);

  import mont_pkg::*;

  localparam int                CW   = (R > 1) ? $clog2(R) : 1;
  localparam logic [DATA_W-1:0] N_W  = DATA_W'(N);
  localparam logic [CW-1:0]     LAST = CW'(R - 1);

  state_t              r_state;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_y;
  logic [CW-1:0]       r_cnt;
  logic                r_valid;
  logic                r_busy;
  logic [DATA_W-1:0]   w_pre;
  logic [DATA_W-1:0]   w_dbl;
  logic                w_reject;

  assign w_pre = (a >= N_W) ? a - N_W : a;

`ifdef MONT_ENC_RANGE_CHK_EN
  logic r_err;
  assign w_reject = (a >= N_W);
  assign err      = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= (r_state == S_IDLE) && en && w_reject;
  end
`else
  assign w_reject = 1'b0;
`endif

  mod_double #(.N(N)) u_mod_double (
    .x (r_acc),
    .y (w_dbl)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (en && !r_busy && !w_reject) begin
            r_acc   <= w_pre;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_acc <= w_dbl;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_y     <= w_dbl;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign y     = r_y;
  assign valid = r_valid;
  assign busy  = r_busy;

endmodule
